// File: rtl/edge_detect_pkg.sv
// Shared limits and helpers for the edge_detect_filt input conditioner.
// Holds parameter bounds and the filter counter width function.
package edge_detect_pkg;

   localparam int NCH_MAX  = 16;
   localparam int SYNC_MAX = 4;
   localparam int FILT_MAX = 255;

   // Counter must hold 0..FILT_LEN-1; never narrower than one bit.
   function automatic int cnt_w(input int filt_len);
      int w;
      w = $clog2(filt_len + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/edge_detect_filt_ch.sv
// Single channel: synchronizer chain, debounce counter, edge pulses.
// Ports: clk, rst_n (sync, active-low), din, level, pos, neg.
module edge_filt_ch
   import edge_detect_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_LEN    = 4,
   parameter logic INIT_VAL    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic pos,
   output logic neg
);

   localparam int CNT_W = cnt_w(FILT_LEN);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= {SYNC_STAGES{INIT_VAL}};
         level <= INIT_VAL;
         cnt   <= '0;
         pos   <= 1'b0;
         neg   <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         pos  <= 1'b0;
         neg  <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            // Level held long enough: accept and pulse in the same cycle.
            level <= s;
            cnt   <= '0;
            pos   <= s;
            neg   <= ~s;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/edge_detect_filt.sv
// Multi-channel synchronizer, glitch filter and edge detector.
// Ports: clk, rst_n, data_in, level_out, pos_edge, neg_edge, any_edge,
// evt_clr, evt_mask, evt_flag, irq. Macro EDGE_STICKY_EN adds sticky
// flags and irq; without it evt_flag/irq are 0 and evt_clr/evt_mask unused.
module edge_detect_filt
   import edge_detect_pkg::*;
#(
   parameter int             NCH         = 2,
   parameter int             SYNC_STAGES = 2,
   parameter int             FILT_LEN    = 4,
   parameter logic [NCH-1:0] INIT_VAL    = {NCH{1'b1}}
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] data_in,
   output logic [NCH-1:0] level_out,
   output logic [NCH-1:0] pos_edge,
   output logic [NCH-1:0] neg_edge,
   output logic           any_edge,
   input  logic [NCH-1:0] evt_clr,
   input  logic [NCH-1:0] evt_mask,
   output logic [NCH-1:0] evt_flag,
   output logic           irq
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      edge_filt_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LEN    (FILT_LEN),
         .INIT_VAL    (INIT_VAL[i])
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (data_in[i]),
         .level (level_out[i]),
         .pos   (pos_edge[i]),
         .neg   (neg_edge[i])
      );
   end

   assign any_edge = |(pos_edge | neg_edge);

`ifdef EDGE_STICKY_EN
   // Set dominates clear so an edge landing with a clear is not lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         evt_flag <= '0;
      end else begin
         evt_flag <= (evt_flag & ~evt_clr) | pos_edge | neg_edge;
      end
   end

   assign irq = |(evt_flag & evt_mask);
`else
   logic unused_evt;

   assign unused_evt = ^{evt_clr, evt_mask};
   assign evt_flag   = '0;
   assign irq        = 1'b0;
`endif

endmodule
